// File: rtl/logic_gate_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : logic_gate_unit
//  Purpose  : Bitwise logic unit with a valid/ready request port and a
//             DEPTH-entry result FIFO on a valid/ready result port.
//             Each accepted request (a, b, op) produces one WIDTH-bit result
//             and its zero flag. Both are stored in the FIFO and presented at
//             the head (c, c_zero) until the consumer takes them.
//  Ports    : clk        - clock, rising edge active
//             rst_n      - asynchronous active-low reset
//             a, b       - operands (WIDTH bits)
//             op         - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                          6 NOT a, 7 pass a
//             in_valid   - request present
//             in_ready   - unit can accept a request (buffer not full)
//             c, c_zero  - head result and its zero flag (0 when empty)
//             out_valid  - head result valid (buffer not empty)
//             out_ready  - consumer takes the head result
//             op_count   - accepted requests since reset, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             c_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      op_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_NAND = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_NOTA = 3'd6;

    // ------------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]   r_zero;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [15:0]        r_op_count;
    // Held low through reset and set on the first edge after release, so
    // in_ready is low while in reset and rises one edge after rst_n does.
    logic               r_ready_en;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_result;

    // ------------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_result = a;
        case (op)
            c_OP_AND:  w_result = a & b;
            c_OP_OR:   w_result = a | b;
            c_OP_XOR:  w_result = a ^ b;
            c_OP_NAND: w_result = ~(a & b);
            c_OP_NOR:  w_result = ~(a | b);
            c_OP_XNOR: w_result = ~(a ^ b);
            c_OP_NOTA: w_result = ~a;
            default:   w_result = a;
        endcase
    end

    // ------------------------------------------------------------------------
    // Handshake qualification. in_ready is built only from registered state,
    // so a pop on the same edge never frees a slot for a push when full.
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign in_ready  = r_ready_en & ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Result storage. Entries need no reset: they are only visible through
    // the head mux below, which is gated by the (reset) occupancy count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, zero flags and request counter. Pointers wrap
    // naturally because DEPTH is a power of two.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_zero     <= '0;
            r_op_count <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;

            if (w_push) begin
                r_zero[r_wr_ptr] <= (w_result == '0);
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                if (r_op_count != 16'hFFFF) begin
                    r_op_count <= r_op_count + 16'd1;
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Head outputs, forced to zero while empty so stale or never-written
    // entries are never visible.
    // ------------------------------------------------------------------------
    assign c        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign c_zero   = ~w_empty & r_zero[r_rd_ptr];
    assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand and result width in bits (legal range 1-32).
REQ-002 The block SHALL have parameter DEPTH, default 4, setting the result-buffer entry count (power of two, 2-16).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port op, input, 3 bits, operation select.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning that a, b and op hold a request.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning that the block can accept a request.
REQ-010 The block SHALL have port c, output, WIDTH bits, the result at the head of the buffer.
REQ-011 The block SHALL have port c_zero, output, 1 bit, high when the head result equals 0.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning that c and c_zero are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning that the consumer accepts c.
REQ-014 The block SHALL have port op_count, output, 16 bits, the number of requests accepted since reset.

Function
REQ-015 The block SHALL decode op as follows: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (b ignored), 7 pass a; every operation is bitwise over WIDTH bits.
REQ-016 The block SHALL accept a request on a rising edge where in_valid=1 and in_ready=1, computing the result from a, b and op sampled at that edge.
REQ-017 The block SHALL write each accepted result, together with its zero flag, into a FIFO of DEPTH entries.
REQ-018 The block SHALL assert out_valid one cycle after acceptance into an empty buffer; there is no combinational input-to-output path.
REQ-019 The block SHALL drive in_ready = NOT full, registered-state based; in_ready SHALL NOT depend on out_ready in the same cycle.
REQ-020 The block SHALL pop the head entry on a rising edge where out_valid=1 and out_ready=1.
REQ-021 The block SHALL keep c and c_zero stable while out_valid=1 and out_ready=0.
REQ-022 The block SHALL perform both a push and a pop on the same edge when both are legal, leaving the occupancy unchanged.
REQ-023 The block SHALL keep read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0, and an occupancy count of 0 to DEPTH.
REQ-024 Full SHALL mean count=DEPTH and empty SHALL mean count=0; out_valid = NOT empty.
REQ-025 The block SHALL ignore in_valid when in_ready=0; no state changes and nothing is dropped or overwritten.
REQ-026 The block SHALL ignore out_ready when out_valid=0.
REQ-027 The block SHALL increment op_count by 1 per accepted request, saturating at 16'hFFFF.
REQ-028 The block SHALL keep c and c_zero as X-free zeros when the buffer is empty.

Reset
REQ-029 When rst_n=0, the block SHALL immediately drive count=0, both pointers=0, op_count=0, out_valid=0, c=0, c_zero=0 and in_ready=0.
REQ-030 The block SHALL drive in_ready=1 on the first rising edge after rst_n is released.
REQ-031 The block SHALL discard all buffered results on a reset asserted mid-operation; no stale entry appears after release.

Verification
REQ-032 Bench SHALL check, with WIDTH=8 and out_ready=1: a=8'hF0, b=8'h3C issued as op 0-7 in turn -> c = 30, FC, CC, CF, 03, 33, 0F, F0 in order, each one cycle after acceptance.
REQ-033 Bench SHALL check that a=8'hAA, b=8'hAA with op=2 gives c=8'h00 with c_zero=1.
REQ-034 Bench SHALL check back-pressure: with out_ready=0, after 4 accepts (DEPTH=4) in_ready=0; a fifth in_valid is ignored and op_count=4; then raising out_ready drains exactly 4 results in order.
REQ-035 Bench SHALL check simultaneous push and pop: at count=2, a push and a pop on the same edge leave count=2, and the head advances.
REQ-036 Bench SHALL check reset mid-operation: with 3 entries buffered, a pulse of rst_n=0 gives out_valid=0 and op_count=0 immediately, and in_ready=1 one edge after release.
REQ-037 Bench SHALL check wrap-around with 10 push/pop pairs through DEPTH=4: results stay in order and no entry is lost or duplicated.
